// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: source encodings and
// the width of the source-1 starvation counter.
package wb_port_arbiter_pkg;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    // Bits needed to count 0..starve_max inclusive (never less than 1).
    function automatic int starve_cnt_w(input int starve_max);
        return (starve_max < 1) ? 1 : $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/wb_out_reg.sv
// Load-enabled register with asynchronous active-high reset to zero.
module wb_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d only when ld_en is set; otherwise keep the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the ALU result
// path (source 0) and the LSU/MDU result path (source 1). The ALU wins by
// default; source 1 is promoted once it has lost STARVE_MAX cycles while
// valid. The winner is registered and drives the register file next cycle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [AW-1:0] s0_rd,
    input  logic [DW-1:0] s0_data,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [AW-1:0] s1_rd,
    input  logic [DW-1:0] s1_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_wsrc,
    output logic          starved
);

    localparam int            CW      = starve_cnt_w(STARVE_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
    localparam int            OW      = AW + DW + 1;

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_nxt;

    logic          xfer_p0;
    logic          win_p0;
    logic [AW-1:0] rd_p0;
    logic [DW-1:0] data_p0;
    logic [OW-1:0] out_q_p1;

    // Grant selection, winner mux and next starvation count.
    always_comb begin
        starved        = (starve_cnt == CNT_MAX);
        s1_ready       = !hold && s1_valid && (!s0_valid || starved);
        s0_ready       = !hold && s0_valid && !(s1_valid && starved);
        xfer_p0        = s0_ready || s1_ready;
        win_p0         = s1_ready ? SRC_LSU : SRC_ALU;
        rd_p0          = s1_ready ? s1_rd   : s0_rd;
        data_p0        = s1_ready ? s1_data : s0_data;
        starve_cnt_nxt = starve_cnt;
        if (s1_ready) begin
            starve_cnt_nxt = '0;
        end else if (s1_valid && (starve_cnt != CNT_MAX)) begin
            // Losing cycles count even while held downstream.
            starve_cnt_nxt = starve_cnt + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // ---- stage p0 -> p1: registered write port ----

    // Write enable reloads every cycle; writes to x0 are accepted but dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
        end else begin
            rf_we <= xfer_p0 && (rd_p0 != '0);
        end
    end

    wb_out_reg #(
        .W (OW)
    ) u_out_reg (
        .clk   (clk),
        .rst   (rst),
        .ld_en (xfer_p0),
        .d     ({rd_p0, data_p0, win_p0}),
        .q     (out_q_p1)
    );

    assign {rf_waddr, rf_wdata, rf_wsrc} = out_q_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed vectors followed by a
// constrained random run against a small behavioural model.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SM = 3;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
        logic          src;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          hold;
    logic          s0_valid;
    logic          s0_ready;
    logic [AW-1:0] s0_rd;
    logic [DW-1:0] s0_data;
    logic          s1_valid;
    logic          s1_ready;
    logic [AW-1:0] s1_rd;
    logic [DW-1:0] s1_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_wsrc;
    logic          starved;

    wb_port_arbiter #(
        .DW         (DW),
        .AW         (AW),
        .STARVE_MAX (SM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_rd    (s0_rd),
        .s0_data  (s0_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_rd    (s1_rd),
        .s1_data  (s1_data),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_wsrc  (rf_wsrc),
        .starved  (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    logic [2:0] rq[$];   // expected {s0_ready, s1_ready, starved} per cycle
    wr_t        wq[$];   // expected register-file writes in order

    // model state for the random phase
    int            mcnt = 0;
    logic          p0 = 1'b0, p1 = 1'b0;
    logic [AW-1:0] r0 = '0, r1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    int            loss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares readies every driven cycle and each write the DUT issues.
    always @(negedge clk) begin
        logic [2:0] er;
        wr_t        ew;
        if (rq.size() > 0) begin
            er = rq.pop_front();
            check("ready", {61'd0, s0_ready, s1_ready, starved}, {61'd0, er});
        end
        if (rf_we === 1'b1) begin
            if (wq.size() == 0) begin
                check("unexpected_write", {26'd0, rf_waddr, rf_wdata, rf_wsrc}, 64'd0);
            end else begin
                ew = wq.pop_front();
                check("write", {26'd0, rf_waddr, rf_wdata, rf_wsrc}, {26'd0, ew});
            end
        end
    end

    // One clock of stimulus with hand-supplied expected readies/starved.
    task automatic drive_cycle(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] x0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] x1,
                               input logic h, input logic e0, input logic e1, input logic es);
        s0_valid = v0; s0_rd = a0; s0_data = x0;
        s1_valid = v1; s1_rd = a1; s1_data = x1;
        hold = h;
        rq.push_back({e0, e1, es});
        if (e0 && a0 != '0) wq.push_back('{rd: a0, d: x0, src: 1'b0});
        if (e1 && a1 != '0) wq.push_back('{rd: a1, d: x1, src: 1'b1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic es);
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, es);
    endtask

    // Random step: new requests/hold when allowed, expectations from the model.
    task automatic rand_step(input logic allow_new);
        logic h, stv, g0, g1;
        if (allow_new && !p0 && $urandom_range(0, 99) < 60) begin
            p0 = 1'b1; r0 = AW'($urandom_range(0, 31)); d0 = $urandom;
        end
        if (allow_new && !p1 && $urandom_range(0, 99) < 50) begin
            p1 = 1'b1; r1 = AW'($urandom_range(0, 31)); d1 = $urandom;
        end
        h   = allow_new && ($urandom_range(0, 9) == 0);
        stv = (mcnt == SM);
        g1  = !h && p1 && (!p0 || stv);
        g0  = !h && p0 && !g1;
        if (p0 && p1 && !h && !g1) loss++;
        if (g1) begin
            check("starve_bound", 64'(loss), 64'(loss <= SM ? loss : SM));
            loss = 0;
        end
        drive_cycle(p0, r0, d0, p1, r1, d1, h, g0, g1, stv);
        if (g1) mcnt = 0;
        else if (p1 && mcnt < SM) mcnt++;
        if (g0) p0 = 1'b0;
        if (g1) p1 = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        int k, j;
        rst = 1'b1; hold = 1'b0;
        s0_valid = 1'b0; s0_rd = '0; s0_data = '0;
        s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
        #12;
        check("rst_we",    64'(rf_we),    64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_wsrc",  64'(rf_wsrc),  64'd0);
        check("rst_starved", 64'(starved), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single ALU write, rd=5
        drive_cycle(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);

        // continuous contention: grants 0,0,0,1,0,0,0,1
        pat = 8'b1000_1000;
        k = 0; j = 0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, AW'(k + 1), DW'(32'h100 + k), 1'b1, AW'(10 + j), DW'(32'hA0 + j),
                        1'b0, !pat[i], pat[i], pat[i]);
            if (pat[i]) j++; else k++;
        end

        // x0 write from source 1 clears the counter
        drive_cycle(1'b1, 5'd20, 32'h200, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd21, 32'h201, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 5'd0,  32'h0,   1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 5'd22, 32'h202, 1'b1, 5'd12, 32'hC0,  1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd23, 32'h203, 1'b1, 5'd12, 32'hC0,  1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd24, 32'h204, 1'b1, 5'd12, 32'hC0,  1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd25, 32'h205, 1'b1, 5'd12, 32'hC0,  1'b0, 1'b0, 1'b1, 1'b1);

        // hold for 5 cycles, counter saturates, source 1 first on release
        drive_cycle(1'b1, 5'd25, 32'h205, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd25, 32'h205, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd25, 32'h205, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 5'd25, 32'h205, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 5'd25, 32'h205, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 5'd25, 32'h205, 1'b1, 5'd13, 32'hD0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b1, 5'd25, 32'h205, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);

        // reset mid-cycle after a handshake: the transfer is lost
        s0_valid = 1'b1; s0_rd = 5'd7; s0_data = 32'h77;
        s1_valid = 1'b0; hold = 1'b0;
        rq.push_back(3'b100);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we",    64'(rf_we),    64'd0);
        check("mid_rst_waddr", 64'(rf_waddr), 64'd0);
        check("mid_rst_wdata", 64'(rf_wdata), 64'd0);
        check("mid_rst_wsrc",  64'(rf_wsrc),  64'd0);
        check("mid_rst_ready", 64'(s0_ready), 64'd1);
        s0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1'b0);
        idle(1'b0);

        // random traffic against the model
        mcnt = 0; p0 = 1'b0; p1 = 1'b0; loss = 0;
        for (int i = 0; i < 10000; i++) rand_step(1'b1);
        for (int i = 0; i < 10; i++) rand_step(1'b0);
        idle(mcnt == SM);
        idle(mcnt == SM);

        check("pending_writes", 64'(wq.size()), 64'd0);
        check("pending_readies", 64'(rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between two writeback sources: the single-cycle ALU result path (source 0) and the long-latency LSU/MDU result path (source 1). Arbitration uses fixed priority to the ALU with a starvation counter that promotes source 1 after a bounded wait. The winning result is captured in load-enabled output registers that drive the register file one cycle after the handshake. Sits between the EX/MEM result stages and the register file write port.

## Interface
- DW, 32, data width
- AW, 5, register index width
- STARVE_MAX, 3, cycles source 1 may lose while valid before it gains priority (≥1)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- hold  in  1  downstream stall; no grant while high
- s0_valid  in  1  ALU result valid
- s0_ready  out  1  ALU result accepted this cycle
- s0_rd  in  AW  ALU destination index
- s0_data  in  DW  ALU result
- s1_valid  in  1  LSU/MDU result valid
- s1_ready  out  1  LSU/MDU result accepted this cycle
- s1_rd  in  AW  LSU/MDU destination index
- s1_data  in  DW  LSU/MDU result
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  write index
- rf_wdata  out  DW  write data
- rf_wsrc  out  1  source of current write (0 = ALU, 1 = LSU/MDU)
- starved  out  1  source 1 currently holds promoted priority

## Operation
- Handshake: transfer when sX_valid && sX_ready. Once valid, a source keeps valid, rd and data stable until ready. sX_ready is combinational from the current valids, hold and the starvation count.
- Grant rule (hold = 0): only one valid → grant it. Both valid → grant source 1 if starve_cnt == STARVE_MAX, else grant source 0. At most one ready per cycle.
- hold = 1: both readies 0; output registers load rf_we = 0.
- Starvation counter, width clog2(STARVE_MAX+1):
  - increments, saturating at STARVE_MAX, each cycle s1_valid && !s1_ready, including cycles with hold = 1;
  - clears to 0 on a source 1 transfer;
  - holds its value when s1_valid = 0.
  - starved = (starve_cnt == STARVE_MAX).
- Output register: on a transfer, loads rf_waddr = rd, rf_wdata = data, rf_wsrc = winner, rf_we = (rd != 0). A write to x0 is accepted and dropped. With no transfer, rf_we loads 0 and addr/data/src hold their previous values.

## Timing
- Grant has 0-cycle latency: ready asserts in the same cycle as valid when the source wins.
- Write has 1-cycle latency: rf_* reflect the transfer on the clock edge after the handshake.
- Throughput is one write per cycle with no bubble between back-to-back grants.
- Reset (asynchronous, any time, including mid-transfer):
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, rf_wsrc = 0, starve_cnt = 0;
  - readies follow the combinational rule from the reset state;
  - an in-flight transfer is lost and no write issues.
- With STARVE_MAX = 1, source 1 wins on its second contested cycle.
- Continuous contention produces the grant pattern STARVE_MAX × source 0, then 1 × source 1, repeating.

## Structure
- Shared core package holds SRC_ALU = 1'b0, SRC_LSU = 1'b1, and the starvation-count width function.
- Sub-module wb_out_reg is a load-enabled register with asynchronous active-high reset and zero reset value. It is instantiated for {rf_waddr, rf_wdata, rf_wsrc} with ld_en = transfer. rf_we is a plain register loaded every cycle.
- Arbitration and the counter are a single combinational block plus a counter register; there is no FSM beyond the counter.

## Test plan
- Reset, then s0_valid with rd=5, data=0x1234 → s0_ready same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, rf_wsrc=0.
- Both valid continuously, STARVE_MAX=3 → grants 0,0,0,1,0,0,0,1; starved high exactly on each source-1 grant cycle.
- s1_valid with rd=0 → s1_ready=1, next cycle rf_we=0, starve_cnt cleared.
- hold high for 5 cycles with both valid → no readies, rf_we=0, starve_cnt saturates at 3; on hold release, source 1 granted first.
- rst asserted mid-cycle after a handshake → all outputs 0 immediately, no write on the following edge.
- Random valids and hold over 10k cycles, checked against a reference model → writes match in order, no lost or duplicated transfers, source 1 never waits more than STARVE_MAX+1 unheld contested cycles.
